// File: rtl/ram_port_ctrl.sv
// Single-port RAM request/response controller with a 2-entry response FIFO.
// Read data bypasses the FIFO when it is empty and the response can be taken immediately.
module ram_port_ctrl #(
  parameter  int DATA_WIDTH = 32,
  parameter  int DEPTH      = 16,
  localparam int ADDR_WIDTH = $clog2(DEPTH),
  localparam int BWEN_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wen,
  input  logic [BWEN_WIDTH-1:0] req_bwen,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  ram_cen,
  output logic                  ram_wen,
  output logic [BWEN_WIDTH-1:0] ram_bwen,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout
);

  logic                  inflight;
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [1:0]            fifo_count;
  logic [DATA_WIDTH-1:0] fifo_mem [2];

  logic [1:0] occupancy;
  logic       read_ok;
  logic       accept;
  logic       rd_accept;
  logic       fifo_empty;
  logic       bypass;
  logic       push;
  logic       pop;

  // A read may only issue if its response is guaranteed a FIFO slot.
  always_comb begin
    occupancy  = fifo_count + {1'b0, inflight};
    read_ok    = (occupancy < 2'd2);
    req_ready  = req_wen | read_ok;
    accept     = req_valid & req_ready;
    rd_accept  = accept & ~req_wen;
    fifo_empty = (fifo_count == 2'd0);
  end

  always_comb begin
    ram_cen  = accept;
    ram_wen  = req_wen;
    ram_bwen = req_bwen;
    ram_addr = req_addr;
    ram_din  = req_wdata;
  end

  // Bypass the FIFO only when it holds nothing older than the RAM output.
  always_comb begin
    bypass    = inflight & fifo_empty;
    rsp_valid = inflight | ~fifo_empty;
    rsp_rdata = bypass ? ram_dout : fifo_mem[rd_ptr];
    push      = inflight & ~(bypass & rsp_ready);
    pop       = ~fifo_empty & rsp_ready;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      inflight <= 1'b0;
    end else begin
      inflight <= rd_accept;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      fifo_count <= 2'd0;
    end else begin
      if (push) begin
        wr_ptr <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 2'd1;
        2'b01:   fifo_count <= fifo_count - 2'd1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      fifo_mem[wr_ptr] <= ram_dout;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clock) begin
    if (reset_n) begin
      assert (!(push && fifo_count == 2'd2))
        else $error("response FIFO overflow");
    end
  end
`endif

endmodule

// File: doc/ram_port_ctrl.md
RAM_PORT_CTRL -- requirements
Module: ram_port_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: data word width in bits, a multiple of 8.
REQ-002 SHALL have parameter DEPTH, default 16: RAM depth in words.
REQ-003 SHALL derive local parameters ADDR_WIDTH = $clog2(DEPTH) and BWEN_WIDTH = DATA_WIDTH/8.
REQ-004 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-005 clock  input  1  sole clock; all state updates on rising edge.
REQ-006 reset_n  input  1  asynchronous active-low reset.
REQ-007 req_valid  input  1  upstream request valid.
REQ-008 req_ready  output  1  request accepted when req_valid && req_ready.
REQ-009 req_wen  input  1  1 = write, 0 = read.
REQ-010 req_bwen  input  BWEN_WIDTH  byte write enables; bit i covers data bits [8i+7:8i].
REQ-011 req_addr  input  ADDR_WIDTH  word address.
REQ-012 req_wdata  input  DATA_WIDTH  write data.
REQ-013 rsp_valid  output  1  read response valid.
REQ-014 rsp_ready  input  1  downstream accepts response when rsp_valid && rsp_ready.
REQ-015 rsp_rdata  output  DATA_WIDTH  read data.
REQ-016 ram_cen / ram_wen  output  1 each  RAM port chip enable / write enable.
REQ-017 ram_bwen / ram_addr / ram_din  output  BWEN_WIDTH / ADDR_WIDTH / DATA_WIDTH  RAM port controls and write data.
REQ-018 ram_dout  input  DATA_WIDTH  RAM read data, valid the cycle after a read is issued.

Function
REQ-019 Accept = req_valid && req_ready; ram_cen SHALL equal accept combinationally, and ram_wen, ram_bwen, ram_addr and ram_din SHALL equal req_wen, req_bwen, req_addr and req_wdata.
REQ-020 Write requests SHALL always be accepted (req_ready=1 when req_wen=1) and SHALL produce no response.
REQ-021 Read requests SHALL be accepted only when occupancy < 2, where occupancy = fifo_count + inflight.
REQ-022 inflight SHALL be a 1-bit register, set on the edge that accepts a read and cleared otherwise.
REQ-023 The block SHALL contain a 2-entry response FIFO: a 1-bit write pointer, a 1-bit read pointer and a 2-bit count in the range 0..2.
REQ-024 Bypass: when inflight=1 and fifo_count=0, rsp_valid=1 and rsp_rdata=ram_dout combinationally; if rsp_ready=1, the word SHALL NOT enter the FIFO.
REQ-025 Otherwise rsp_valid = (fifo_count != 0) and rsp_rdata = FIFO head; an inflight word SHALL be pushed into the FIFO on that edge.
REQ-026 Simultaneous push and pop SHALL leave fifo_count unchanged and advance both pointers.
REQ-027 Pointers SHALL wrap 1 -> 0.
REQ-028 The FIFO SHALL never overflow, guaranteed by REQ-021; push while count=2 is unreachable and SHALL be asserted in simulation.
REQ-029 Read latency SHALL be 1 cycle from accept to rsp_valid via the bypass path, with rsp_ready held at 1.
REQ-030 Sustained back-to-back reads SHALL achieve 1 response per cycle when rsp_ready=1.
REQ-031 Responses SHALL be returned strictly in request order.
REQ-032 rsp_valid SHALL NOT depend on rsp_ready.
REQ-033 Once asserted, rsp_valid and rsp_rdata SHALL hold until the response is accepted.

Reset
REQ-034 While reset_n=0: inflight=0, fifo_count=0, pointers=0; rsp_valid=0 and ram_cen=0 unless a request is presented.
REQ-035 Reset asserted mid-operation SHALL discard inflight reads and queued responses; no stale response SHALL appear after release.
REQ-036 FIFO storage SHALL NOT be reset.

Verification
REQ-037 Write, then read: write addr 3, data 0xA5A5A5A5, bwen 4'b1111; then read addr 3 with rsp_ready=1 -> rsp_valid the cycle after read accept, rsp_rdata=0xA5A5A5A5.
REQ-038 Byte mask: write 0x11223344 to addr 5, then write 0xFFFFFFFF with bwen 4'b0101 -> read of addr 5 returns 0x11FF33FF.
REQ-039 Backpressure: rsp_ready=0, read addrs 0, 1, 2 back-to-back -> third read stalls (req_ready=0); release rsp_ready -> responses arrive in order 0, 1, 2 with no loss.
REQ-040 Throughput: rsp_ready=1, 8 consecutive reads -> req_ready stays 1, 8 responses in 8 consecutive cycles.
REQ-041 Mixed traffic: during a read stall with FIFO full, present a write -> accepted immediately; ram_wen=1 that cycle.
REQ-042 Reset mid-stream: assert reset_n=0 with 2 responses queued -> after release rsp_valid=0 and fifo_count=0.
